crop_paste: RTL and testbench

Inverse of the crop stage. Accepts a PATCH_ROWS×PATCH_COLS pixel stream plus a per-frame placement coordinate (Y1, X1) over AXI-Stream-style handshakes. Emits a full FRAME_ROWS×FRAME_COLS raster stream with the patch inserted at (Y1, X1) and FILL_VALUE everywhere else. Sits downstream of crop/filter processing to restore full-frame geometry for display or re-composition.

---
 rtl/crop_paste.sv | 164 ++++++++++++++++
 tb/tb_crop_paste.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/crop_paste.sv
// crop_paste: re-inserts a cropped patch into a full-size raster frame.
// Placement coordinates are captured and clamped once per frame. The frame is
// then streamed out in raster order: patch pixels inside the window, FILL_VALUE
// everywhere else.
//
// state      | meaning
// WAIT_COORD | collecting Y1/X1 placement; leaves once both are captured
// STREAM     | walking the frame raster and loading the output register
module crop_paste #(
    parameter int PIXEL_BIT_WIDTH  = 12,
    parameter int FRAME_ROWS       = 40,
    parameter int FRAME_COLS       = 40,
    parameter int PATCH_ROWS       = 20,
    parameter int PATCH_COLS       = 20,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PIXEL_BIT_WIDTH-1:0]  patch_in_TDATA_i,
    input  logic                        patch_in_TVALID_i,
    output logic                        patch_in_TREADY_o,
    input  logic [IMG_ROW_BITWIDTH-1:0] place_Y1_TDATA_i,
    input  logic                        place_Y1_TVALID_i,
    output logic                        place_Y1_TREADY_o,
    input  logic [IMG_COL_BITWIDTH-1:0] place_X1_TDATA_i,
    input  logic                        place_X1_TVALID_i,
    output logic                        place_X1_TREADY_o,
    output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA_o,
    output logic                        pixel_out_TVALID_o,
    input  logic                        pixel_out_TREADY_i,
    output logic                        pixel_out_TUSER_o,
    output logic                        pixel_out_TLAST_o
);
    localparam int RW = IMG_ROW_BITWIDTH;
    localparam int CW = IMG_COL_BITWIDTH;
    localparam logic [RW-1:0] Y_MAX    = RW'(FRAME_ROWS - PATCH_ROWS);
    localparam logic [CW-1:0] X_MAX    = CW'(FRAME_COLS - PATCH_COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(FRAME_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(FRAME_COLS - 1);

    typedef enum logic {WAIT_COORD, STREAM} state_t;

    state_t                     state_q, state_d;
    logic                       y_rcvd_q, y_rcvd_d, x_rcvd_q, x_rcvd_d;
    logic [RW-1:0]              y1_q, y1_d, y_q, y_d;
    logic [CW-1:0]              x1_q, x1_d, x_q, x_d;
    logic [PIXEL_BIT_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d, user_q, user_d, last_q, last_d;

    logic in_win, slot_free, load;

    // Window test is done one bit wider so Y1c+PATCH_ROWS cannot wrap.
    always_comb begin
        in_win = ({1'b0, y_q} >= {1'b0, y1_q}) &&
                 ({1'b0, y_q} <  ({1'b0, y1_q} + (RW+1)'(PATCH_ROWS))) &&
                 ({1'b0, x_q} >= {1'b0, x1_q}) &&
                 ({1'b0, x_q} <  ({1'b0, x1_q} + (CW+1)'(PATCH_COLS)));
        slot_free = !valid_q || pixel_out_TREADY_i;
    end

    // Next-state, handshake readies and output-register load decision.
    always_comb begin
        state_d  = state_q;
        y_rcvd_d = y_rcvd_q;
        x_rcvd_d = x_rcvd_q;
        y1_d     = y1_q;
        x1_d     = x1_q;
        y_d      = y_q;
        x_d      = x_q;
        data_d   = data_q;
        user_d   = user_q;
        last_d   = last_q;
        valid_d  = valid_q;
        load     = 1'b0;
        place_Y1_TREADY_o = 1'b0;
        place_X1_TREADY_o = 1'b0;
        patch_in_TREADY_o = 1'b0;

        case (state_q)
            WAIT_COORD: begin
                place_Y1_TREADY_o = !y_rcvd_q;
                place_X1_TREADY_o = !x_rcvd_q;
                if (place_Y1_TVALID_i && !y_rcvd_q) begin
                    y_rcvd_d = 1'b1;
                    y1_d     = (place_Y1_TDATA_i > Y_MAX) ? Y_MAX : place_Y1_TDATA_i;
                end
                if (place_X1_TVALID_i && !x_rcvd_q) begin
                    x_rcvd_d = 1'b1;
                    x1_d     = (place_X1_TDATA_i > X_MAX) ? X_MAX : place_X1_TDATA_i;
                end
                if (y_rcvd_q && x_rcvd_q) begin
                    state_d = STREAM;
                    y_d     = '0;
                    x_d     = '0;
                end
            end
            STREAM: begin
                patch_in_TREADY_o = in_win && slot_free;
                load = slot_free && (in_win ? patch_in_TVALID_i : 1'b1);
                if (load) begin
                    if (x_q == LAST_COL) begin
                        x_d = '0;
                        if (y_q == LAST_ROW) begin
                            y_d      = '0;
                            y_rcvd_d = 1'b0;
                            x_rcvd_d = 1'b0;
                            state_d  = WAIT_COORD;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_COORD;
        endcase

        if (load) begin
            data_d  = in_win ? patch_in_TDATA_i : FILL_VALUE;
            user_d  = (x_q == '0) && (y_q == '0);
            last_d  = (x_q == LAST_COL);
            valid_d = 1'b1;
        end else if (pixel_out_TREADY_i) begin
            valid_d = 1'b0;
        end
    end

    // State, counters, coordinates and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_COORD;
            y_rcvd_q <= 1'b0;
            x_rcvd_q <= 1'b0;
            y1_q     <= '0;
            x1_q     <= '0;
            y_q      <= '0;
            x_q      <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            user_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_rcvd_q <= y_rcvd_d;
            x_rcvd_q <= x_rcvd_d;
            y1_q     <= y1_d;
            x1_q     <= x1_d;
            y_q      <= y_d;
            x_q      <= x_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            user_q   <= user_d;
            last_q   <= last_d;
        end
    end

    assign pixel_out_TDATA_o  = data_q;
    assign pixel_out_TVALID_o = valid_q;
    assign pixel_out_TUSER_o  = user_q;
    assign pixel_out_TLAST_o  = last_q;
endmodule

// File: tb/tb_crop_paste.sv
// Directed bench for crop_paste on an 8x8 frame with a 3x3 patch.
module tb_crop_paste;
    localparam int FR = 8, FC = 8, PR = 3, PC = 3, NPIX = FR * FC, NPATCH = PR * PC;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] patch_in_TDATA;
    logic        patch_in_TVALID, patch_in_TREADY;
    logic [9:0]  place_Y1_TDATA, place_X1_TDATA;
    logic        place_Y1_TVALID, place_Y1_TREADY, place_X1_TVALID, place_X1_TREADY;
    logic [11:0] pixel_out_TDATA;
    logic        pixel_out_TVALID, pixel_out_TREADY, pixel_out_TUSER, pixel_out_TLAST;

    crop_paste #(
        .PIXEL_BIT_WIDTH(12), .FRAME_ROWS(FR), .FRAME_COLS(FC),
        .PATCH_ROWS(PR), .PATCH_COLS(PC),
        .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10), .FILL_VALUE(12'd0)
    ) dut (
        .clk(clk), .reset(reset),
        .patch_in_TDATA_i(patch_in_TDATA), .patch_in_TVALID_i(patch_in_TVALID),
        .patch_in_TREADY_o(patch_in_TREADY),
        .place_Y1_TDATA_i(place_Y1_TDATA), .place_Y1_TVALID_i(place_Y1_TVALID),
        .place_Y1_TREADY_o(place_Y1_TREADY),
        .place_X1_TDATA_i(place_X1_TDATA), .place_X1_TVALID_i(place_X1_TVALID),
        .place_X1_TREADY_o(place_X1_TREADY),
        .pixel_out_TDATA_o(pixel_out_TDATA), .pixel_out_TVALID_o(pixel_out_TVALID),
        .pixel_out_TREADY_i(pixel_out_TREADY), .pixel_out_TUSER_o(pixel_out_TUSER),
        .pixel_out_TLAST_o(pixel_out_TLAST)
    );

    initial forever #5 clk = ~clk;

    // y1/x1 as presented, ey/ex the hand-clamped placement, base = first patch pixel,
    // mode 0 = free flowing, mode 1 = toggling TREADY plus random patch gaps.
    typedef struct {
        int y1; int x1; int ey; int ex; int base; int mode;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int in_win(input int idx, input int p);
        int r, c;
        r = p / FC;
        c = p % FC;
        return (r >= vecs[idx].ey && r < vecs[idx].ey + PR &&
                c >= vecs[idx].ex && c < vecs[idx].ex + PC) ? 1 : 0;
    endfunction

    function automatic int exp_pix(input int idx, input int p);
        int r, c;
        r = p / FC;
        c = p % FC;
        if (in_win(idx, p) == 0) return 0;
        return vecs[idx].base + (r - vecs[idx].ey) * PC + (c - vecs[idx].ex);
    endfunction

    // Streams nf consecutive frames starting at table entry 'first', stopping
    // after n_stop output handshakes. The next frame's coordinates are presented
    // as soon as the previous ones are taken.
    task automatic run_frames(input int first, input int nf, input int n_stop);
        int   n, pi, cy, cx, lcnt, f, p, m;
        logic had_stall, pu_q, pl_q;
        logic [11:0] pd_q;
        n = 0; pi = 0; cy = 0; cx = 0;
        had_stall = 1'b0; pu_q = 1'b0; pl_q = 1'b0; pd_q = '0;
        m = vecs[first].mode;
        for (int cyc = 0; cyc < 3000 && n < n_stop; cyc++) begin
            @(negedge clk);
            pixel_out_TREADY = (m == 1) ? (cyc % 2 == 0) : 1'b1;
            place_Y1_TVALID  = (cy < nf);
            place_Y1_TDATA   = (cy < nf) ? 10'(vecs[first + cy].y1) : 10'd0;
            place_X1_TVALID  = (cx < nf);
            place_X1_TDATA   = (cx < nf) ? 10'(vecs[first + cx].x1) : 10'd0;
            if (pi < NPATCH * nf) begin
                patch_in_TVALID = (m == 0) || ($urandom_range(0, 3) != 0);
                patch_in_TDATA  = 12'(vecs[first + pi / NPATCH].base + pi % NPATCH);
            end else begin
                patch_in_TVALID = 1'b0;
                patch_in_TDATA  = 12'hfff;
            end
            #1;
            if (had_stall) begin
                chk("stall_valid_hold", int'(pixel_out_TVALID), 1);
                chk("stall_data_hold", int'(pixel_out_TDATA), int'(pd_q));
                chk("stall_user_hold", int'(pixel_out_TUSER), int'(pu_q));
                chk("stall_last_hold", int'(pixel_out_TLAST), int'(pl_q));
            end
            had_stall = pixel_out_TVALID && !pixel_out_TREADY;
            pd_q = pixel_out_TDATA; pu_q = pixel_out_TUSER; pl_q = pixel_out_TLAST;

            lcnt = n + int'(pixel_out_TVALID);
            if (patch_in_TREADY) begin
                f = lcnt / NPIX;
                chk("patch_ready_in_window", (f < nf) ? in_win(first + f, lcnt % NPIX) : 0, 1);
            end
            if (m == 0 && nf == 1 && n > 0 && n < NPIX)
                chk("continuous_valid", int'(pixel_out_TVALID), 1);
            if (place_Y1_TVALID && place_Y1_TREADY) begin
                if (cy > 0) chk("y_accept_after_prev_frame", int'(lcnt >= NPIX * cy), 1);
                cy++;
            end
            if (place_X1_TVALID && place_X1_TREADY) begin
                if (cx > 0) chk("x_accept_after_prev_frame", int'(lcnt >= NPIX * cx), 1);
                cx++;
            end
            if (patch_in_TVALID && patch_in_TREADY) pi++;
            if (pixel_out_TVALID && pixel_out_TREADY) begin
                f = n / NPIX;
                p = n % NPIX;
                chk($sformatf("pix_f%0d_r%0d_c%0d", f, p / FC, p % FC),
                    int'(pixel_out_TDATA), exp_pix(first + f, p));
                chk($sformatf("tuser_f%0d_p%0d", f, p), int'(pixel_out_TUSER), int'(p == 0));
                chk($sformatf("tlast_f%0d_p%0d", f, p), int'(pixel_out_TLAST), int'(p % FC == FC - 1));
                n++;
            end
        end
        chk("handshake_budget", n, n_stop);
        if (n_stop == NPIX * nf) chk("patch_consumed", pi, NPATCH * nf);
        @(negedge clk);
        patch_in_TVALID = 1'b0;
        place_Y1_TVALID = 1'b0;
        place_X1_TVALID = 1'b0;
    endtask

    initial begin
        vecs[0] = '{y1: 2, x1: 3, ey: 2, ex: 3, base: 1,  mode: 0}; // basic paste
        vecs[1] = '{y1: 7, x1: 6, ey: 5, ex: 5, base: 1,  mode: 0}; // clamp
        vecs[2] = '{y1: 2, x1: 3, ey: 2, ex: 3, base: 1,  mode: 1}; // backpressure
        vecs[3] = '{y1: 0, x1: 0, ey: 0, ex: 0, base: 1,  mode: 0}; // back-to-back A
        vecs[4] = '{y1: 5, x1: 5, ey: 5, ex: 5, base: 11, mode: 0}; // back-to-back B
        vecs[5] = '{y1: 2, x1: 3, ey: 2, ex: 3, base: 1,  mode: 0}; // abandoned frame
        vecs[6] = '{y1: 1, x1: 1, ey: 1, ex: 1, base: 21, mode: 0}; // after mid-frame reset

        reset = 1'b1;
        patch_in_TDATA = '0; patch_in_TVALID = 1'b0;
        place_Y1_TDATA = 10'd4; place_Y1_TVALID = 1'b1;
        place_X1_TDATA = 10'd4; place_X1_TVALID = 1'b1;
        pixel_out_TREADY = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        place_Y1_TVALID = 1'b0;
        place_X1_TVALID = 1'b0;
        #1;
        chk("rst_tvalid", int'(pixel_out_TVALID), 0);
        chk("rst_tdata", int'(pixel_out_TDATA), 0);
        chk("rst_tuser", int'(pixel_out_TUSER), 0);
        chk("rst_tlast", int'(pixel_out_TLAST), 0);
        chk("rst_patch_ready", int'(patch_in_TREADY), 0);
        chk("rst_y_ready", int'(place_Y1_TREADY), 1);
        chk("rst_x_ready", int'(place_X1_TREADY), 1);

        for (int i = 0; i < 3; i++) run_frames(i, 1, NPIX);

        run_frames(3, 2, 2 * NPIX);

        // Reset after 20 output handshakes; hold TREADY low so only reset can clear TVALID.
        run_frames(5, 1, 20);
        reset = 1'b1;
        pixel_out_TREADY = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tvalid", int'(pixel_out_TVALID), 0);
        chk("midrst_patch_ready", int'(patch_in_TREADY), 0);
        chk("midrst_y_ready", int'(place_Y1_TREADY), 1);
        chk("midrst_x_ready", int'(place_X1_TREADY), 1);
        @(negedge clk);
        place_Y1_TDATA = 10'd6; place_Y1_TVALID = 1'b1;
        place_X1_TDATA = 10'd6; place_X1_TVALID = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        place_Y1_TVALID = 1'b0;
        place_X1_TVALID = 1'b0;
        #1;
        chk("postrst_y_ready", int'(place_Y1_TREADY), 1);
        chk("postrst_x_ready", int'(place_X1_TREADY), 1);
        run_frames(6, 1, NPIX);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
